// File: rtl/reg_dump_streamer_pkg.sv
// Shared types and constants for the register-file dump streamer.
package dbg_pkg;

  typedef enum logic [1:0] {IDLE, HDR, DATA, CSUM} dump_state_e;

  localparam logic [7:0] DUMP_HDR_BYTE = 8'hA5;

  // Header byte + all register bytes + checksum byte.
  function automatic int frame_bytes(input int num_regs, input int xlen);
    return 2 + num_regs * (xlen / 8);
  endfunction

endpackage

// File: rtl/reg_dump_streamer_if.sv
// Byte stream with valid/ready handshake from the dump streamer to its consumer.
interface reg_dump_streamer_if;

  logic [7:0] m_data;
  logic       m_valid;
  logic       m_ready;

  modport master (output m_data, output m_valid, input m_ready);
  modport slave  (input m_data, input m_valid, output m_ready);

endinterface

// File: rtl/reg_dump_streamer_byte_serializer.sv
// Splits one XLEN word into XLEN/8 bytes, least significant first, over valid/ready.
module byte_serializer #(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [XLEN-1:0] word,
  input  logic            word_valid,
  output logic [7:0]      data,
  output logic            valid,
  input  logic            ready,
  output logic            word_done
);

  localparam int NBYTES = XLEN / 8;
  localparam int BW     = (NBYTES > 1) ? $clog2(NBYTES) : 1;

  logic [BW-1:0] byte_idx;
  logic          last;

  assign valid     = word_valid;
  assign data      = word[8*byte_idx +: 8];
  assign last      = (byte_idx == BW'(NBYTES - 1));
  assign word_done = valid && ready && last;

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values regardless of evaluation order.
  always_ff @(posedge clk) begin
    if (rst) begin
      byte_idx <= '0;
    end else if (valid && ready) begin
      byte_idx <= last ? '0 : byte_idx + 1'b1;
    end
  end

endmodule

// File: rtl/reg_dump_streamer.sv
// Captures the register-file snapshot on start and streams it as a framed,
// checksummed byte stream: header, registers little-endian, XOR checksum.
module reg_dump_streamer
  import dbg_pkg::*;
#(
  parameter int         NUM_REGS = 32,
  parameter int         XLEN     = 32,
  parameter logic [7:0] HDR_BYTE = DUMP_HDR_BYTE
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [NUM_REGS*XLEN-1:0] regs,
  input  logic                     start,
  output logic                     busy,
  output logic                     done,
  reg_dump_streamer_if.master      m
);

  localparam int RW = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1;

  dump_state_e     state;
  logic [XLEN-1:0] snap [NUM_REGS];
  logic [RW-1:0]   reg_idx;
  logic [7:0]      checksum;
  logic            valid_q;

  logic [7:0]      ser_data;
  logic            ser_valid;
  logic            ser_word_done;
  logic            accept;
  logic            data_accept;

  assign m.m_valid   = valid_q;
  assign accept      = valid_q && m.m_ready;
  assign data_accept = ser_valid && m.m_ready;

  byte_serializer #(.XLEN(XLEN)) u_ser (
    .clk        (clk),
    .rst        (rst),
    .word       (snap[reg_idx]),
    .word_valid (state == DATA),
    .data       (ser_data),
    .valid      (ser_valid),
    .ready      (m.m_ready),
    .word_done  (ser_word_done)
  );

  // NOTE: the snapshot is pure datapath storage; it is always written before it
  // is read, so it carries no reset and can map onto plain flops or RAM.
  always_ff @(posedge clk) begin
    if (state == IDLE && start) begin
      for (int i = 0; i < NUM_REGS; i++) begin
        snap[i] <= regs[i*XLEN +: XLEN];
      end
    end
  end

  // Output byte is a pure function of registered state, so it never depends on m_ready.
  // NOTE: every always_comb output gets a default first so no latch can be inferred.
  always_comb begin
    m.m_data = 8'h00;
    unique case (state)
      IDLE: m.m_data = 8'h00;
      HDR:  m.m_data = HDR_BYTE;
      DATA: m.m_data = ser_data;
      CSUM: m.m_data = checksum;
      default: m.m_data = 8'h00;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      busy     <= 1'b0;
      done     <= 1'b0;
      valid_q  <= 1'b0;
      reg_idx  <= '0;
      checksum <= 8'h00;
    end else begin
      done <= 1'b0;
      unique case (state)
        IDLE: if (start) begin
          state    <= HDR;
          busy     <= 1'b1;
          valid_q  <= 1'b1;
          reg_idx  <= '0;
          checksum <= 8'h00;
        end
        HDR: if (accept) begin
          state   <= DATA;
          reg_idx <= '0;
        end
        DATA: if (data_accept) begin
          checksum <= checksum ^ ser_data;
          if (ser_word_done) begin
            if (reg_idx == RW'(NUM_REGS - 1)) state <= CSUM;
            else                              reg_idx <= reg_idx + 1'b1;
          end
        end
        CSUM: if (accept) begin
          state   <= IDLE;
          valid_q <= 1'b0;
          busy    <= 1'b0;
          done    <= 1'b1;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
